bist_command_sequencer: RTL and testbench

Registered, parametrised successor to the BIST command decoder. It accepts opcode/select commands over a valid/ready handshake and drives the per-logic-block clock enable for a programmable number of cycles. It also sequences result-capture and end-of-test flags and reports illegal commands. It sits between the JTAG instruction/data register path and the array of logic-under-test blocks.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/bist_command_sequencer_if.sv | 24 ++
 rtl/bist_run_counter.sv | 38 +++
 rtl/bist_command_sequencer.sv | 138 +++++++++++++
 tb/tb_bist_command_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST command sequencer.
// Provides the opcode values, the 2-bit sequencer state encoding and the
// default field widths used by the interface, the top level and the counter.
package bist_pkg;

  // Default field widths
  localparam int SEL_W_DEF = 4;
  localparam int OP_W_DEF  = 4;
  localparam int CYC_W_DEF = 8;

  // Opcodes carried in the upper field of the command word
  localparam int OP_END    = 0;
  localparam int OP_RUN    = 1;
  localparam int OP_RESULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bist_command_sequencer_if.sv
// Command handshake between the JTAG-side issuer and the sequencer.
//   cmd_in    : {opcode, select} command word
//   run_len   : RUN length, sampled when the command is accepted
//   cmd_valid : command present, held until accepted
//   cmd_ready : sequencer accepts a command this cycle
// master = command issuer, slave = sequencer.
interface bist_command_sequencer_if
  import bist_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int CYC_W = CYC_W_DEF
);
  localparam int CMD_W = OP_W + SEL_W;

  logic [CMD_W-1:0] cmd_in;
  logic [CYC_W-1:0] run_len;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (output cmd_in, output run_len, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_in, input run_len, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/bist_run_counter.sv
// Loadable down-counter that times the RUN phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes effect at the next edge)
//   en         : decrement by one; saturates at zero
//   clr        : force the count to zero; highest priority
//   load_val   : value to load
//   last       : count currently equals one (final enabled cycle)
module bist_run_counter
  import bist_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             clr,
  input  logic [CYC_W-1:0] load_val,
  output logic             last
);

  logic [CYC_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CYC_W'(1);
    end
  end

  assign last = (count_reg == CYC_W'(1));

endmodule

// File: rtl/bist_command_sequencer.sv
// BIST command sequencer: accepts {opcode, select} commands over a
// valid/ready handshake and drives the clock enable of the selected logic
// block for a programmed number of cycles, strobes result capture, holds a
// sticky end-of-test flag and reports unknown opcodes.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd          : command handshake (slave side)
//   abort        : synchronous abort, returns to IDLE and blocks acceptance
//   To_Logic_X   : selected logic block
//   log_clk_en   : clock enable to the selected block
//   log_res_flag : one-cycle result-capture strobe
//   End_flag     : sticky end-of-test flag
//   run_done     : one-cycle pulse after a RUN completes
//   illegal_cmd  : one-cycle pulse for an unknown opcode
//   busy         : sequencer is in RUN or RESULT
module bist_command_sequencer
  import bist_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bist_command_sequencer_if.slave     cmd,
  input  logic                        abort,
  output logic [SEL_W-1:0]            To_Logic_X,
  output logic                        log_clk_en,
  output logic                        log_res_flag,
  output logic                        End_flag,
  output logic                        run_done,
  output logic                        illegal_cmd,
  output logic                        busy
);

  localparam int CMD_W = OP_W + SEL_W;
  localparam logic [OP_W-1:0] OPC_END    = OP_W'(OP_END);
  localparam logic [OP_W-1:0] OPC_RUN    = OP_W'(OP_RUN);
  localparam logic [OP_W-1:0] OPC_RESULT = OP_W'(OP_RESULT);

  state_t           state_reg;
  logic [OP_W-1:0]  opcode;
  logic [SEL_W-1:0] select;
  logic             accept;
  logic             cnt_load;
  logic             cnt_last;

  assign opcode = cmd.cmd_in[CMD_W-1:SEL_W];
  assign select = cmd.cmd_in[SEL_W-1:0];

  // Only combinational output: ready in the command-taking states, masked by abort.
  assign cmd.cmd_ready = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && !abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // A zero-length RUN never enters RUN, so the counter is only loaded for N>0.
  assign cnt_load = accept && (opcode == OPC_RUN) && (cmd.run_len != '0);

  bist_run_counter #(.CYC_W(CYC_W)) u_run_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (state_reg == ST_RUN),
    .clr      (abort),
    .load_val (cmd.run_len),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      To_Logic_X   <= '0;
      log_clk_en   <= 1'b0;
      log_res_flag <= 1'b0;
      End_flag     <= 1'b0;
      run_done     <= 1'b0;
      illegal_cmd  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle
      run_done     <= 1'b0;
      illegal_cmd  <= 1'b0;
      log_res_flag <= 1'b0;
      if (abort) begin
        state_reg  <= ST_IDLE;
        log_clk_en <= 1'b0;
        End_flag   <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (accept) begin
              case (opcode)
                OPC_RUN: begin
                  To_Logic_X <= select;
                  End_flag   <= 1'b0;
                  if (cmd.run_len == '0) begin
                    state_reg <= ST_IDLE;
                    run_done  <= 1'b1;
                  end else begin
                    state_reg  <= ST_RUN;
                    log_clk_en <= 1'b1;
                    busy       <= 1'b1;
                  end
                end
                OPC_RESULT: begin
                  state_reg    <= ST_RESULT;
                  log_res_flag <= 1'b1;
                  busy         <= 1'b1;
                  End_flag     <= 1'b0;
                end
                OPC_END: begin
                  state_reg  <= ST_DONE;
                  End_flag   <= 1'b1;
                  To_Logic_X <= '0;
                end
                // Unknown opcode leaves state and End_flag untouched
                default: illegal_cmd <= 1'b1;
              endcase
            end
          end
          ST_RUN: begin
            if (cnt_last) begin
              state_reg  <= ST_IDLE;
              log_clk_en <= 1'b0;
              busy       <= 1'b0;
              run_done   <= 1'b1;
            end
          end
          ST_RESULT: begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_command_sequencer.sv
// Testbench for bist_command_sequencer: a directed per-cycle vector table,
// hand-written abort and asynchronous-reset sequences, then randomized
// commands checked against a cycle-scheduled reference model.
module tb_bist_command_sequencer;
  import bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] To_Logic_X;
  logic       log_clk_en, log_res_flag, End_flag, run_done, illegal_cmd, busy;

  int n_vec = 0;
  int n_err = 0;

  bist_command_sequencer_if #(.SEL_W(4), .OP_W(4), .CYC_W(8)) cif();

  bist_command_sequencer #(.SEL_W(4), .OP_W(4), .CYC_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cif),
    .abort        (abort),
    .To_Logic_X   (To_Logic_X),
    .log_clk_en   (log_clk_en),
    .log_res_flag (log_res_flag),
    .End_flag     (End_flag),
    .run_done     (run_done),
    .illegal_cmd  (illegal_cmd),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       rep;
    bit       v;
    bit [7:0] cmd;
    bit [7:0] len;
    bit       ab;
    bit       rdy, en, res, endf, rd, ill, bsy;
    bit [3:0] sel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rep, bit v, bit [7:0] c, bit [7:0] l, bit ab,
                              bit rdy, bit en, bit res, bit endf, bit rd, bit ill,
                              bit bsy, bit [3:0] sel);
    vec_t t;
    t.rep = rep; t.v = v; t.cmd = c; t.len = l; t.ab = ab;
    t.rdy = rdy; t.en = en; t.res = res; t.endf = endf; t.rd = rd; t.ill = ill;
    t.bsy = bsy; t.sel = sel;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit [7:0] c, input bit [7:0] l, input bit a);
    cif.cmd_valid = v;
    cif.cmd_in    = c;
    cif.run_len   = l;
    abort         = a;
  endtask

  task automatic check_outs(input string tag, input bit rdy, input bit en, input bit res,
                            input bit endf, input bit rd, input bit ill, input bit bsy,
                            input bit [3:0] sel);
    chk({tag, ".cmd_ready"},    cif.cmd_ready, rdy);
    chk({tag, ".log_clk_en"},   log_clk_en,    en);
    chk({tag, ".log_res_flag"}, log_res_flag,  res);
    chk({tag, ".End_flag"},     End_flag,      endf);
    chk({tag, ".run_done"},     run_done,      rd);
    chk({tag, ".illegal_cmd"},  illegal_cmd,   ill);
    chk({tag, ".busy"},         busy,          bsy);
    chk({tag, ".To_Logic_X"},   To_Logic_X,    sel);
  endtask

  // Reference model: expected registered outputs scheduled per cycle index.
  bit m_en[1024], m_res[1024], m_rd[1024], m_ill[1024], m_busy[1024];
  int free_at;
  bit end_m;
  bit [3:0] sel_m;

  initial begin
    bit       v, pend, ab, acc, mrdy;
    bit [7:0] c8, l8;
    bit [3:0] op, sl;
    int       r;

    drive(0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1, 0, 0, 0, 0, 0, 0, 4'h0);
    rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    //          rep v  cmd    len ab  rdy en res end rd ill bsy sel
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 1, 8'h15, 3, 0,  1, 0, 0, 0, 0, 0, 0, 4'h0)); // RUN sel5 len3
    tbl.push_back(mk(3, 0, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'h5));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 1, 0, 0, 4'h5));
    tbl.push_back(mk(1, 1, 8'h15, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'h5)); // RUN len0
    tbl.push_back(mk(1, 1, 8'h20, 0, 0,  1, 0, 0, 0, 1, 0, 0, 4'h5)); // RESULT
    tbl.push_back(mk(1, 1, 8'h13, 1, 0,  0, 0, 1, 0, 0, 0, 1, 4'h5)); // held
    tbl.push_back(mk(1, 1, 8'h13, 1, 0,  1, 0, 0, 0, 0, 0, 0, 4'h5)); // accepted
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'h3));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 1, 0, 0, 4'h3));
    tbl.push_back(mk(1, 1, 8'h00, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'h3)); // END
    tbl.push_back(mk(10,0, 8'h00, 0, 0,  1, 0, 0, 1, 0, 0, 0, 4'h0)); // sticky
    tbl.push_back(mk(1, 1, 8'h73, 0, 0,  1, 0, 0, 1, 0, 0, 0, 4'h0)); // opcode 7
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 1, 0, 1, 0, 4'h0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 1, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, 1, 8'h1F, 2, 0,  1, 0, 0, 1, 0, 0, 0, 4'h0)); // RUN selF len2
    tbl.push_back(mk(2, 0, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'hF));
    tbl.push_back(mk(1, 1, 8'h1F, 1, 0,  1, 0, 0, 0, 1, 0, 0, 4'hF)); // back-to-back
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'hF));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 1, 0, 0, 4'hF));
    tbl.push_back(mk(1, 1, 8'h20, 0, 1,  0, 0, 0, 0, 0, 0, 0, 4'hF)); // abort masks
    tbl.push_back(mk(1, 1, 8'h20, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'hF));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  0, 0, 1, 0, 0, 0, 1, 4'hF));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 0, 0, 0, 4'hF));

    foreach (tbl[i]) begin
      if (tbl[i].v)
        $display("row %0d: cmd %02h len %0d abort %0d", i, tbl[i].cmd, tbl[i].len, tbl[i].ab);
      for (int k = 0; k < tbl[i].rep; k++) begin
        drive(tbl[i].v, tbl[i].cmd, tbl[i].len, tbl[i].ab);
        @(negedge clk);
        check_outs($sformatf("row%0d.%0d", i, k), tbl[i].rdy, tbl[i].en, tbl[i].res,
                   tbl[i].endf, tbl[i].rd, tbl[i].ill, tbl[i].bsy, tbl[i].sel);
        @(posedge clk);
        #1;
      end
    end

    // ---------------- abort during a long RUN ----------------
    $display("seq abort: RUN sel9 len200, abort in run cycle 50");
    drive(1, 8'h19, 8'd200, 0);
    @(negedge clk);
    chk("abort.accept_ready", cif.cmd_ready, 1);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 50; k++) begin
      drive(k == 50, 8'h20, 8'd0, k == 50);
      @(negedge clk);
      chk($sformatf("abort.en%0d", k), log_clk_en, 1);
      chk($sformatf("abort.rdy%0d", k), cif.cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    drive(1, 8'h20, 8'd0, 0);
    @(negedge clk);
    chk("abort.en_after", log_clk_en, 0);
    chk("abort.no_run_done", run_done, 0);
    chk("abort.busy_after", busy, 0);
    chk("abort.ready_after", cif.cmd_ready, 1);
    chk("abort.res_not_yet", log_res_flag, 0);
    @(posedge clk);
    #1;
    drive(0, 8'h00, 8'd0, 0);
    @(negedge clk);
    chk("abort.res_strobe", log_res_flag, 1);
    chk("abort.no_run_done2", run_done, 0);
    @(posedge clk);
    #1;

    // ---------------- asynchronous reset mid-RUN ----------------
    $display("seq reset: RUN sel6 len10, rst_n low mid-run");
    drive(1, 8'h16, 8'd10, 0);
    @(posedge clk);
    #1;
    drive(0, 8'h00, 8'd0, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("rst.en_before", log_clk_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst.To_Logic_X", To_Logic_X, 0);
    chk("rst.log_clk_en", log_clk_en, 0);
    chk("rst.busy", busy, 0);
    chk("rst.End_flag", End_flag, 0);
    chk("rst.log_res_flag", log_res_flag, 0);
    chk("rst.run_done", run_done, 0);
    chk("rst.illegal_cmd", illegal_cmd, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready_after", cif.cmd_ready, 1);
    chk("rst.busy_after", busy, 0);
    chk("rst.en_after", log_clk_en, 0);
    @(posedge clk);
    #1;

    // ---------------- randomized against the reference model ----------------
    free_at = 0;
    end_m   = 1'b0;
    sel_m   = 4'h0;
    pend    = 1'b0;
    v = 0; c8 = 0; l8 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r < 4)      op = 4'(OP_RUN);
        else if (r < 6) op = 4'(OP_RESULT);
        else if (r < 8) op = 4'(OP_END);
        else            op = 4'($urandom_range(3, 15));
        sl = 4'($urandom_range(0, 15));
        c8 = {op, sl};
        if ($urandom_range(0, 39) == 0)     l8 = 8'd255;
        else if ($urandom_range(0, 3) == 0) l8 = 8'd0;
        else                                l8 = 8'($urandom_range(1, 12));
      end
      ab = ($urandom_range(0, 24) == 0);
      drive(v, c8, l8, ab);
      @(negedge clk);
      mrdy = (c >= free_at) && !ab;
      check_outs($sformatf("rnd%0d", c), mrdy, m_en[c], m_res[c], end_m,
                 m_rd[c], m_ill[c], m_busy[c], sel_m);
      acc = v && mrdy;
      if (ab) begin
        for (int k = c + 1; k < c + 300; k++) begin
          m_en[k] = 0; m_res[k] = 0; m_rd[k] = 0; m_ill[k] = 0; m_busy[k] = 0;
        end
        end_m   = 1'b0;
        free_at = c + 1;
      end else if (acc) begin
        $display("rnd cycle %0d: accept cmd %02h len %0d", c, c8, l8);
        case (int'(c8[7:4]))
          OP_RUN: begin
            sel_m = c8[3:0];
            end_m = 1'b0;
            for (int k = 1; k <= int'(l8); k++) begin
              m_en[c + k] = 1; m_busy[c + k] = 1;
            end
            m_rd[c + int'(l8) + 1] = 1;
            free_at = c + int'(l8) + 1;
          end
          OP_RESULT: begin
            m_res[c + 1] = 1; m_busy[c + 1] = 1;
            free_at = c + 2;
            end_m = 1'b0;
          end
          OP_END: begin
            end_m = 1'b1;
            sel_m = 4'h0;
          end
          default: m_ill[c + 1] = 1;
        endcase
      end
      pend = v && !acc;
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
